rf_wb_port_arbiter: RTL and testbench
=====================================

// Module: rf_wb_port_arbiter
// PURPOSE
//  Sole owner of the GPR file write port. Arbitrates between the in-order pipeline WB stage
//  (RFWr / link-address / MEM data from the WB decoder) and a multi-cycle mul/div unit that
//  completes out of band. Pipeline writes always win. Mul/div results are buffered in a small
//  FIFO and drained into idle WB slots. A starvation FSM stalls the pipeline when needed.
// PARAMETERS
//  DATA_W      32  register data width
//  ADDR_W      5   register index width
//  MD_DEPTH    2   mul/div result FIFO entries (power of 2, >=2)
//  STARVE_MAX  4   consecutive blocked cycles before a forced drain (>=1)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous reset, active-high
//  pipe_wr    in   1       WB-stage register write request (RFWr)
//  pipe_addr  in   ADDR_W  WB-stage destination register
//  pipe_data  in   DATA_W  WB-stage write data (already muxed MEM/link address)
//  md_valid   in   1       mul/div result valid
//  md_ready   out  1       FIFO can accept; transfer = md_valid & md_ready
//  md_addr    in   ADDR_W  mul/div destination register
//  md_data    in   DATA_W  mul/div result
//  rf_we      out  1       register file write enable
//  rf_waddr   out  ADDR_W  register file write address
//  rf_wdata   out  DATA_W  register file write data
//  pipe_hold  out  1       registered; upstream must inject a WB bubble (pipe_wr=0) this cycle
//  md_pending out  1       FIFO non-empty
// BEHAVIOUR
//  - Reset (async, rst=1): FIFO emptied, pointers/count=0, starve counter=0, FSM=IDLE,
//    pipe_hold=0, md_pending=0, md_ready=1. rf_we is forced 0 while rst=1.
//  - Write port is combinational, zero latency. pipe_eff = pipe_wr & (pipe_addr!=0).
//    If pipe_eff: rf_* = pipe_*. Else if FIFO non-empty: rf_* = head, pop at clock edge.
//    Else rf_we=0, rf_waddr=0, rf_wdata=0.
//  - A pipe_wr to $0 counts as a free slot and may drain the FIFO. md writes to $0 are accepted
//    and discarded at enqueue (no entry).
//  - md_ready = (count < MD_DEPTH) | pop_this_cycle. Push and pop in the same cycle keep count.
//    A push into an empty FIFO is not visible on rf_* until the next cycle.
//  - Ordering: the pipeline write is younger. Any buffered entry whose addr == pipe_addr while
//    pipe_eff is squashed (valid bit cleared, still occupies its slot, pops without writing).
//  - FSM (count = consecutive cycles with FIFO non-empty and no drain):
//    IDLE: FIFO empty. Go to WAIT when FIFO becomes non-empty.
//    WAIT: each blocked cycle increments the counter. A drain clears it. At STARVE_MAX-1 with
//      another blocked cycle, go to FORCE. Go to IDLE when the FIFO empties.
//    FORCE: pipe_hold=1; the head drains this cycle. Then go to WAIT if entries remain, else
//      IDLE; counter=0. If pipe_eff is still 1 in FORCE (protocol violation), the pipeline wins
//      and the FSM stays in FORCE.
//  - pipe_hold depends only on state (registered). md_pending = (count!=0).
// CONFIGURATION
//  WB_ARB_SCOREBOARD_EN defined: adds ports rd_qaddr0/rd_qaddr1 (in, ADDR_W) and
//    rd_qhit0/rd_qhit1 (out, 1). Each hit=1 when a valid, unsquashed FIFO entry targets a
//    non-zero query address. Combinational, for ID-stage hazard stall.
//  Undefined: those ports and that logic are absent. All other behaviour is identical.
// TESTING
//  1 Reset mid-drain: FIFO holds 2 entries, assert rst -> rf_we=0 immediately; after release
//    md_pending=0, md_ready=1, pipe_hold=0.
//  2 Idle slot drain: md push ($8,0x1234) with pipe_wr=0 -> next cycle rf_we=1, waddr=8,
//    wdata=0x1234; md_pending=0 the cycle after.
//  3 Conflict: pipe_wr=1 ($3,0xA) with md push ($4,0xB) -> rf writes $3 first, $4 in the
//    first later cycle with pipe_wr=0.
//  4 Starvation: FIFO holds 1 entry, pipe_wr=1 ($5) every cycle, STARVE_MAX=4 -> pipe_hold=1
//    on the 5th blocked cycle; that cycle rf writes the entry; pipe_hold=0 next cycle.
//  5 Squash/full: buffer $7=0x1, then pipe_wr $7=0x2 -> $7 ends 0x2 and the entry pops with
//    no write. With MD_DEPTH=2 full and no pop, md_ready=0 and a third push is held.
//  6 (SCOREBOARD_EN) entry $9 buffered, rd_qaddr0=9, rd_qaddr1=0 -> rd_qhit0=1, rd_qhit1=0;
//    after the drain, rd_qhit0=0.

Source files
------------

// File: rtl/rf_wb_port_arbiter.sv
// GPR write-port arbiter: pipeline WB writes win; mul/div results queue in a small FIFO and drain
// into idle slots, with a starvation FSM. Define WB_ARB_SCOREBOARD_EN for ID-stage hit queries.
module rf_wb_port_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned MD_DEPTH   = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_wr,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [ADDR_W-1:0] md_addr,
    input  logic [DATA_W-1:0] md_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pipe_hold,
`ifdef WB_ARB_SCOREBOARD_EN
    input  logic [ADDR_W-1:0] rd_qaddr0,
    input  logic [ADDR_W-1:0] rd_qaddr1,
    output logic              rd_qhit0,
    output logic              rd_qhit1,
`endif
    output logic              md_pending
);

    localparam int unsigned PtrW = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(MD_DEPTH + 1);
    localparam int unsigned StW  = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] Full       = CntW'(MD_DEPTH);
    localparam logic [StW-1:0]  StarveLast = StW'(STARVE_MAX - 1);

    typedef enum logic [1:0] {StIdle, StWait, StForce} state_e;

    logic [ADDR_W-1:0]   addr_q [MD_DEPTH];
    logic [DATA_W-1:0]   data_q [MD_DEPTH];
    logic [MD_DEPTH-1:0] valid_q, valid_d;
    logic [PtrW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]     count_q, count_d;
    logic [StW-1:0]      starve_q, starve_d;
    state_e              state_q, state_d;

    logic pipe_eff, fifo_nempty, pop, push, push_valid, blocked;

    assign pipe_eff    = pipe_wr & (pipe_addr != '0);
    assign fifo_nempty = (count_q != '0);
    assign pop         = fifo_nempty & ~pipe_eff;
    assign blocked     = fifo_nempty & pipe_eff;
    assign md_ready    = (count_q < Full) | pop;
    // Writes to $0 complete the handshake but never occupy a slot.
    assign push        = md_valid & md_ready & (md_addr != '0);
    // A same-cycle pipeline write to the same register is younger and supersedes the result.
    assign push_valid  = ~(pipe_eff & (md_addr == pipe_addr));
    assign md_pending  = fifo_nempty;
    assign pipe_hold   = (state_q == StForce);

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (rst) begin
            rf_we = 1'b0;
        end else if (pipe_eff) begin
            rf_we    = 1'b1;
            rf_waddr = pipe_addr;
            rf_wdata = pipe_data;
        end else if (fifo_nempty && valid_q[rd_ptr_q]) begin
            rf_we    = 1'b1;
            rf_waddr = addr_q[rd_ptr_q];
            rf_wdata = data_q[rd_ptr_q];
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < MD_DEPTH; i++) begin
            if (pipe_eff && addr_q[i] == pipe_addr) valid_d[i] = 1'b0;
        end
        if (pop)  valid_d[rd_ptr_q] = 1'b0;
        if (push) valid_d[wr_ptr_q] = push_valid;
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            StIdle: begin
                starve_d = '0;
                if (count_d != '0) state_d = StWait;
            end
            StWait: begin
                if (blocked) begin
                    if (starve_q == StarveLast) begin
                        state_d  = StForce;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_q + 1'b1;
                    end
                end else begin
                    starve_d = '0;
                    state_d  = (count_d != '0) ? StWait : StIdle;
                end
            end
            StForce: begin
                // Pipeline still writing while held: it wins and the drain is retried.
                if (pop) begin
                    starve_d = '0;
                    state_d  = (count_d != '0) ? StWait : StIdle;
                end
            end
            default: begin
                state_d  = StIdle;
                starve_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            starve_q <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= md_addr;
            data_q[wr_ptr_q] <= md_data;
        end
    end

`ifdef WB_ARB_SCOREBOARD_EN
    always_comb begin
        rd_qhit0 = 1'b0;
        rd_qhit1 = 1'b0;
        for (int i = 0; i < MD_DEPTH; i++) begin
            if (valid_q[i] && addr_q[i] == rd_qaddr0) rd_qhit0 = 1'b1;
            if (valid_q[i] && addr_q[i] == rd_qaddr1) rd_qhit1 = 1'b1;
        end
        if (rd_qaddr0 == '0) rd_qhit0 = 1'b0;
        if (rd_qaddr1 == '0) rd_qhit1 = 1'b0;
    end
`endif

endmodule

// File: tb/tb_rf_wb_port_arbiter.sv
// Self-checking bench for rf_wb_port_arbiter: expected register-file writes are queued as stimulus
// is driven and matched against every rf_we pulse; scenario tasks check timing and status inline.
module tb_rf_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wr;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pipe_hold;
    logic        md_pending;
`ifdef WB_ARB_SCOREBOARD_EN
    logic [4:0]  rd_qaddr0;
    logic [4:0]  rd_qaddr1;
    logic        rd_qhit0;
    logic        rd_qhit1;
`endif

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    rf_wb_port_arbiter #(
        .DATA_W    (32),
        .ADDR_W    (5),
        .MD_DEPTH  (2),
        .STARVE_MAX(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pipe_wr   (pipe_wr),
        .pipe_addr (pipe_addr),
        .pipe_data (pipe_data),
        .md_valid  (md_valid),
        .md_ready  (md_ready),
        .md_addr   (md_addr),
        .md_data   (md_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pipe_hold (pipe_hold),
`ifdef WB_ARB_SCOREBOARD_EN
        .rd_qaddr0 (rd_qaddr0),
        .rd_qaddr1 (rd_qaddr1),
        .rd_qhit0  (rd_qhit0),
        .rd_qhit1  (rd_qhit1),
`endif
        .md_pending(md_pending)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write the DUT performs must be the oldest outstanding expectation.
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (!rst && rf_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got addr=%0d data=%h exp none", rf_waddr, rf_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({rf_waddr, rf_wdata} !== e) begin
                        errors++;
                        $display("FAIL sb_write got addr=%0d data=%h exp addr=%0d data=%h",
                                 rf_waddr, rf_wdata, e[36:32], e[31:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_wr = 0; pipe_addr = 0; pipe_data = 0;
        md_valid = 0; md_addr = 0; md_data = 0;
`ifdef WB_ARB_SCOREBOARD_EN
        rd_qaddr0 = 0; rd_qaddr1 = 0;
`endif
    endtask

    task automatic drive_pipe(input logic wr, input logic [4:0] a, input logic [31:0] d);
        pipe_wr = wr; pipe_addr = a; pipe_data = d;
        if (wr && a != 0) exp_q.push_back({a, d});
    endtask

    task automatic drive_md(input logic v, input logic [4:0] a, input logic [31:0] d);
        md_valid = v; md_addr = a; md_data = d;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        tick();
        pipe_wr = 1; pipe_addr = 3; pipe_data = 32'hdead; drive_md(1, 8, 32'h1);
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", rf_we); end
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", md_ready); end
        checks++; if (md_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", md_pending); end
        checks++; if (pipe_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got=%b exp=0", pipe_hold); end
        idle_inputs();
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_idle_drain();
        drive_md(1, 8, 32'h1234);
        exp_q.push_back({5'd8, 32'h1234});
        @(negedge clk);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL drain_latency got=%b exp=0", rf_we); end
        tick();
        drive_md(0, 0, 0);
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h1234) begin
            errors++; $display("FAIL drain_write got we=%b a=%0d d=%h exp 1/8/1234", rf_we, rf_waddr, rf_wdata);
        end
        checks++; if (md_pending !== 1'b1) begin errors++; $display("FAIL drain_pend1 got=%b exp=1", md_pending); end
        tick();
        @(negedge clk);
        checks++; if (md_pending !== 1'b0) begin errors++; $display("FAIL drain_pend0 got=%b exp=0", md_pending); end
        tick();
    endtask

    task automatic test_conflict();
        drive_pipe(1, 3, 32'hA); drive_md(1, 4, 32'hB);
        @(negedge clk);
        checks++; if (rf_waddr !== 5'd3 || rf_wdata !== 32'hA) begin
            errors++; $display("FAIL conflict_pipe got a=%0d d=%h exp 3/a", rf_waddr, rf_wdata);
        end
        tick();
        drive_pipe(1, 6, 32'hC); drive_md(0, 0, 0);
        @(negedge clk);
        checks++; if (rf_waddr !== 5'd6 || md_pending !== 1'b1) begin
            errors++; $display("FAIL conflict_pipe2 got a=%0d pend=%b exp 6/1", rf_waddr, md_pending);
        end
        tick();
        drive_pipe(0, 0, 0);
        exp_q.push_back({5'd4, 32'hB});
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'hB) begin
            errors++; $display("FAIL conflict_md got we=%b a=%0d d=%h exp 1/4/b", rf_we, rf_waddr, rf_wdata);
        end
        tick();
    endtask

    task automatic test_starvation();
        drive_pipe(1, 5, 32'h500); drive_md(1, 12, 32'h55);
        tick();
        drive_md(0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            drive_pipe(1, 5, 32'h500 + i);
            @(negedge clk);
            checks++; if (pipe_hold !== 1'b0) begin
                errors++; $display("FAIL starve_early cycle=%0d got=%b exp=0", i, pipe_hold);
            end
            tick();
        end
        checks++; if (pipe_hold !== 1'b1) begin errors++; $display("FAIL starve_hold got=%b exp=1", pipe_hold); end
        drive_pipe(0, 0, 0);
        exp_q.push_back({5'd12, 32'h55});
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12) begin
            errors++; $display("FAIL starve_drain got we=%b a=%0d exp 1/12", rf_we, rf_waddr);
        end
        tick();
        checks++; if (pipe_hold !== 1'b0 || md_pending !== 1'b0) begin
            errors++; $display("FAIL starve_release got hold=%b pend=%b exp 0/0", pipe_hold, md_pending);
        end
    endtask

    task automatic test_squash_full();
        drive_pipe(1, 2, 32'h20); drive_md(1, 7, 32'h1);
        tick();
        drive_pipe(1, 7, 32'h2); drive_md(1, 9, 32'h99);
        @(negedge clk);
        checks++; if (rf_waddr !== 5'd7 || rf_wdata !== 32'h2) begin
            errors++; $display("FAIL squash_pipe got a=%0d d=%h exp 7/2", rf_waddr, rf_wdata);
        end
        tick();
        drive_pipe(1, 2, 32'h21); drive_md(1, 10, 32'h10);
        @(negedge clk);
        checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", md_ready); end
        tick();
        drive_pipe(0, 0, 0);
        @(negedge clk);
        checks++; if (rf_we !== 1'b0) begin
            errors++; $display("FAIL squash_nowrite got we=%b a=%0d exp we=0", rf_we, rf_waddr);
        end
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready got=%b exp=1", md_ready); end
        tick();
        drive_md(0, 0, 0);
        exp_q.push_back({5'd9, 32'h99});
        tick();
        exp_q.push_back({5'd10, 32'h10});
        tick();
        @(negedge clk);
        checks++; if (md_pending !== 1'b0) begin errors++; $display("FAIL squash_empty got=%b exp=0", md_pending); end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        drive_pipe(1, 5, 32'h600); drive_md(1, 10, 32'hA0);
        tick();
        drive_pipe(1, 5, 32'h601); drive_md(1, 11, 32'hB0);
        tick();
        drive_pipe(1, 5, 32'h602); drive_md(0, 0, 0);
        @(negedge clk);
        checks++; if (md_pending !== 1'b1 || md_ready !== 1'b0) begin
            errors++; $display("FAIL mid_full got pend=%b ready=%b exp 1/0", md_pending, md_ready);
        end
        tick();
        drive_pipe(0, 0, 0);
        rst = 1;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we got=%b exp=0", rf_we); end
        tick();
        rst = 0;
        #1;
        checks++; if (md_pending !== 1'b0 || md_ready !== 1'b1 || pipe_hold !== 1'b0) begin
            errors++; $display("FAIL mid_release got pend=%b ready=%b hold=%b exp 0/1/0",
                               md_pending, md_ready, pipe_hold);
        end
        tick();
        @(negedge clk);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_flushed got=%b exp=0", rf_we); end
        tick();
    endtask

`ifdef WB_ARB_SCOREBOARD_EN
    task automatic test_scoreboard();
        drive_pipe(1, 5, 32'h700); drive_md(1, 9, 32'h9);
        rd_qaddr0 = 9; rd_qaddr1 = 0;
        tick();
        drive_pipe(1, 5, 32'h701); drive_md(0, 0, 0);
        @(negedge clk);
        checks++; if (rd_qhit0 !== 1'b1 || rd_qhit1 !== 1'b0) begin
            errors++; $display("FAIL qhit_buffered got %b/%b exp 1/0", rd_qhit0, rd_qhit1);
        end
        tick();
        drive_pipe(0, 0, 0);
        exp_q.push_back({5'd9, 32'h9});
        tick();
        @(negedge clk);
        checks++; if (rd_qhit0 !== 1'b0) begin errors++; $display("FAIL qhit_drained got=%b exp=0", rd_qhit0); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_idle_drain();
        test_conflict();
        test_starvation();
        test_squash_full();
        test_reset_mid_drain();
`ifdef WB_ARB_SCOREBOARD_EN
        test_scoreboard();
`endif
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover got=%0d exp=0 outstanding writes", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
